tanh_share_arbiter: RTL and testbench
=====================================

TANH_SHARE_ARBITER -- requirements
Module: tanh_share_arbiter

Interface
REQ-001 The block SHALL have parameter NREQ, default 4, number of requesters sharing one tanh engine.
REQ-002 The block SHALL have parameter ANGLE_W, default 16, signed Q4.12 angle width.
REQ-003 The block SHALL have parameter TANH_W, default 17, signed Q4.13 result width.
REQ-004 The block SHALL have parameter TIMEOUT_CYC, default 63, maximum WAIT-state cycles before abort.
REQ-005 The block SHALL have port Clk, input, 1, clock; all logic on its rising edge.
REQ-006 The block SHALL have port Reset, input, 1, reset: synchronous, active-low.
REQ-007 The block SHALL have port req, input, NREQ, per-requester request, held high until ack.
REQ-008 The block SHALL have port angle, input, NREQ*ANGLE_W, per-requester angle; slice i valid while req[i]=1.
REQ-009 The block SHALL have port ack, output, NREQ, one-hot one-cycle pulse: angle of that requester captured.
REQ-010 The block SHALL have port eng_start, output, 1, one-cycle start pulse to the engine.
REQ-011 The block SHALL have port eng_angle, output, ANGLE_W, angle driven to the engine.
REQ-012 The block SHALL have port eng_done, input, 1, engine result-valid strobe.
REQ-013 The block SHALL have port eng_tanh, input, TANH_W, engine result, valid when eng_done=1.
REQ-014 The block SHALL have port rsp_valid, output, 1, one-cycle response pulse.
REQ-015 The block SHALL have port rsp_id, output, clog2(NREQ), requester index of the response.
REQ-016 The block SHALL have port rsp_tanh, output, TANH_W, result; 0 when rsp_err=1.
REQ-017 The block SHALL have port rsp_err, output, 1, timeout flag qualified by rsp_valid.
REQ-018 The block SHALL have port busy, output, 1, high in every state except IDLE.

Function
REQ-019 The FSM SHALL have states IDLE, ISSUE, WAIT, RESP; all outputs registered.
REQ-020 In IDLE with any req bit high, the block SHALL select the first set bit at or above rr_ptr (wrapping), latch its index and angle, and go to ISSUE next cycle.
REQ-021 In ISSUE (exactly one cycle), the block SHALL assert ack[sel]=1, eng_start=1 and eng_angle=latched angle, clear the timer, and go to WAIT.
REQ-022 eng_done SHALL be ignored in IDLE, ISSUE and RESP.
REQ-023 In WAIT, eng_done=1 SHALL capture eng_tanh into rsp_tanh and go to RESP; eng_angle SHALL hold the latched value throughout WAIT.
REQ-024 In WAIT, the timer SHALL increment each cycle; on reaching TIMEOUT_CYC without eng_done, the block SHALL set rsp_err=1 and rsp_tanh=0 and go to RESP; if eng_done and timeout coincide, eng_done SHALL win.
REQ-025 In RESP (one cycle), rsp_valid=1 with rsp_id=sel; rr_ptr SHALL become (sel+1) mod NREQ; next state SHALL be IDLE.
REQ-026 Minimum request-to-response SHALL be: req seen in IDLE at cycle 0, ack/eng_start at cycle 1, eng_done at cycle k≥2, rsp_valid at cycle k+1.
REQ-027 A req still high on return to IDLE SHALL be treated as a new request.
REQ-028 Angle and result values SHALL pass through unmodified, with no width conversion.

Reset
REQ-029 With Reset=0 at a clock edge, the block SHALL go to IDLE, set rr_ptr=0 and timer=0, and drive ack, eng_start, eng_angle, rsp_valid, rsp_id, rsp_tanh, rsp_err and busy to 0, regardless of current state.
REQ-030 A reset during WAIT SHALL drop the in-flight request with no response; a late eng_done after reset SHALL be ignored.

Structure
REQ-031 Package mlp_act_pkg SHALL hold the state enum, ANGLE_W/TANH_W defaults and the Q-format constants.
REQ-032 Round-robin selection SHALL live in sub-module rr_priority_pick (inputs req, ptr; outputs valid, index).

Verification
REQ-033 Single request: req[1]=1, angle=0x1000, engine returns 0x185F after 26 cycles -> ack[1] at cycle 1, rsp_valid at cycle 28, rsp_id=1, rsp_tanh=0x185F, rsp_err=0.
REQ-034 All four requesters high at once, rr_ptr=0 -> responses in id order 0,1,2,3, one eng_start per response.
REQ-035 After id 2 is served, req[0] and req[3] pending -> id 3 served before id 0.
REQ-036 Engine never asserts eng_done -> rsp_valid exactly TIMEOUT_CYC+1 cycles after eng_start, with rsp_err=1 and rsp_tanh=0; next request proceeds normally.
REQ-037 Reset=0 for one cycle mid-WAIT, then eng_done=1 -> no rsp_valid, all outputs 0, busy=0, rr_ptr=0.
REQ-038 eng_done=1 during ISSUE -> ignored; response occurs only on a later eng_done.

Source files
------------

// File: rtl/mlp_act_pkg.sv
// Shared types and fixed-point constants for the activation datapath.
package mlp_act_pkg;

    // Arbiter FSM states.
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_RESP  = 2'd3
    } arb_state_t;

    // Default datapath widths: angle is signed Q4.12, tanh result is signed Q4.13.
    localparam int ANGLE_W_DEF = 16;
    localparam int TANH_W_DEF  = 17;

    // Q-format fraction bits and the encoding of 1.0 in each format.
    localparam int ANGLE_FRAC = 12;
    localparam int TANH_FRAC  = 13;
    localparam logic [ANGLE_W_DEF-1:0] ANGLE_ONE = ANGLE_W_DEF'(1 << ANGLE_FRAC);
    localparam logic [TANH_W_DEF-1:0]  TANH_ONE  = TANH_W_DEF'(1 << TANH_FRAC);

endpackage

// File: rtl/rr_priority_pick.sv
// Round-robin pick: first set request at or above ptr, wrapping past NREQ-1.
module rr_priority_pick #(
    parameter int NREQ = 4,
    parameter int IDW  = $clog2(NREQ)
) (
    input  logic [NREQ-1:0] req,
    input  logic [IDW-1:0]  ptr,
    output logic            valid,
    output logic [IDW-1:0]  index
);

    // Scan offsets from farthest to nearest so the nearest hit is written last.
    always_comb begin : pick
        logic [IDW-1:0] cand;
        valid = 1'b0;
        index = '0;
        cand  = '0;
        for (int off = NREQ - 1; off >= 0; off--) begin
            cand = IDW'((int'(ptr) + off) % NREQ);
            if (req[cand]) begin
                valid = 1'b1;
                index = cand;
            end
        end
    end

endmodule

// File: rtl/tanh_share_arbiter.sv
// Shares one tanh engine between NREQ requesters with round-robin order and
// a WAIT-state timeout. Every output comes straight from a register.
module tanh_share_arbiter import mlp_act_pkg::*; #(
    parameter int NREQ        = 4,
    parameter int ANGLE_W     = ANGLE_W_DEF,
    parameter int TANH_W      = TANH_W_DEF,
    parameter int TIMEOUT_CYC = 63
) (
    input  logic                      Clk,
    input  logic                      Reset,
    input  logic [NREQ-1:0]           req,
    input  logic [NREQ*ANGLE_W-1:0]   angle,
    output logic [NREQ-1:0]           ack,
    output logic                      eng_start,
    output logic [ANGLE_W-1:0]        eng_angle,
    input  logic                      eng_done,
    input  logic [TANH_W-1:0]         eng_tanh,
    output logic                      rsp_valid,
    output logic [$clog2(NREQ)-1:0]   rsp_id,
    output logic [TANH_W-1:0]         rsp_tanh,
    output logic                      rsp_err,
    output logic                      busy
);

    localparam int IDW = $clog2(NREQ);
    localparam int TW  = $clog2(TIMEOUT_CYC + 1);

    arb_state_t state_q, state_d;

    logic [NREQ-1:0][ANGLE_W-1:0] angle_arr;
    logic [IDW-1:0]     sel_q, sel_d;
    logic [IDW-1:0]     rr_ptr_q, rr_ptr_d;
    logic [TW-1:0]      timer_q, timer_d;
    logic [NREQ-1:0]    ack_q, ack_d;
    logic               eng_start_q, eng_start_d;
    logic [ANGLE_W-1:0] eng_angle_q, eng_angle_d;
    logic               rsp_valid_q, rsp_valid_d;
    logic [IDW-1:0]     rsp_id_q, rsp_id_d;
    logic [TANH_W-1:0]  rsp_tanh_q, rsp_tanh_d;
    logic               rsp_err_q, rsp_err_d;
    logic               busy_q, busy_d;

    logic               pick_valid;
    logic [IDW-1:0]     pick_idx;

    assign angle_arr = angle;

    rr_priority_pick #(.NREQ(NREQ), .IDW(IDW)) u_pick (
        .req   (req),
        .ptr   (rr_ptr_q),
        .valid (pick_valid),
        .index (pick_idx)
    );

    // Next-state and next-output logic; ack/start/valid are one-cycle pulses.
    always_comb begin
        state_d     = state_q;
        sel_d       = sel_q;
        rr_ptr_d    = rr_ptr_q;
        timer_d     = timer_q;
        ack_d       = '0;
        eng_start_d = 1'b0;
        eng_angle_d = eng_angle_q;
        rsp_valid_d = 1'b0;
        rsp_id_d    = rsp_id_q;
        rsp_tanh_d  = rsp_tanh_q;
        rsp_err_d   = rsp_err_q;
        case (state_q)
            ST_IDLE: begin
                // Latch the winner now so ack/start are registered in ISSUE.
                if (pick_valid) begin
                    sel_d           = pick_idx;
                    eng_angle_d     = angle_arr[pick_idx];
                    ack_d[pick_idx] = 1'b1;
                    eng_start_d     = 1'b1;
                    state_d         = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                timer_d = '0;
                state_d = ST_WAIT;
            end
            ST_WAIT: begin
                // A result arriving on the timeout cycle still counts as success.
                if (eng_done) begin
                    rsp_tanh_d  = eng_tanh;
                    rsp_err_d   = 1'b0;
                    rsp_valid_d = 1'b1;
                    rsp_id_d    = sel_q;
                    state_d     = ST_RESP;
                end else if (timer_q == TW'(TIMEOUT_CYC - 1)) begin
                    rsp_tanh_d  = '0;
                    rsp_err_d   = 1'b1;
                    rsp_valid_d = 1'b1;
                    rsp_id_d    = sel_q;
                    state_d     = ST_RESP;
                end else begin
                    timer_d = timer_q + TW'(1);
                end
            end
            ST_RESP: begin
                rr_ptr_d = (sel_q == IDW'(NREQ - 1)) ? '0 : sel_q + IDW'(1);
                state_d  = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
        busy_d = (state_d != ST_IDLE);
    end

    // State and output registers with synchronous active-low reset.
    always_ff @(posedge Clk) begin
        if (!Reset) begin
            state_q     <= ST_IDLE;
            sel_q       <= '0;
            rr_ptr_q    <= '0;
            timer_q     <= '0;
            ack_q       <= '0;
            eng_start_q <= 1'b0;
            eng_angle_q <= '0;
            rsp_valid_q <= 1'b0;
            rsp_id_q    <= '0;
            rsp_tanh_q  <= '0;
            rsp_err_q   <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            sel_q       <= sel_d;
            rr_ptr_q    <= rr_ptr_d;
            timer_q     <= timer_d;
            ack_q       <= ack_d;
            eng_start_q <= eng_start_d;
            eng_angle_q <= eng_angle_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_id_q    <= rsp_id_d;
            rsp_tanh_q  <= rsp_tanh_d;
            rsp_err_q   <= rsp_err_d;
            busy_q      <= busy_d;
        end
    end

    assign ack       = ack_q;
    assign eng_start = eng_start_q;
    assign eng_angle = eng_angle_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_id    = rsp_id_q;
    assign rsp_tanh  = rsp_tanh_q;
    assign rsp_err   = rsp_err_q;
    assign busy      = busy_q;

endmodule

// File: tb/tb_tanh_share_arbiter.sv
// Directed bench for tanh_share_arbiter: round-robin order, latency, timeout, reset.
module tb_tanh_share_arbiter;
    import mlp_act_pkg::*;

    localparam int NREQ    = 4;
    localparam int ANGLE_W = 16;
    localparam int TANH_W  = 17;
    localparam int TMO     = 63;

    logic                         Clk = 1'b0;
    logic                         Reset;
    logic [NREQ-1:0]              req;
    logic [NREQ-1:0][ANGLE_W-1:0] ang_arr;
    logic [NREQ*ANGLE_W-1:0]      angle_v;
    logic [NREQ-1:0]              ack;
    logic                         eng_start;
    logic [ANGLE_W-1:0]           eng_angle;
    logic                         eng_done;
    logic [TANH_W-1:0]            eng_tanh;
    logic                         rsp_valid;
    logic [1:0]                   rsp_id;
    logic [TANH_W-1:0]            rsp_tanh;
    logic                         rsp_err;
    logic                         busy;

    int total = 0;
    int bad   = 0;
    int n_start = 0;

    assign angle_v = ang_arr;

    tanh_share_arbiter #(.NREQ(NREQ), .ANGLE_W(ANGLE_W), .TANH_W(TANH_W), .TIMEOUT_CYC(TMO)) dut (
        .Clk(Clk), .Reset(Reset), .req(req), .angle(angle_v), .ack(ack),
        .eng_start(eng_start), .eng_angle(eng_angle), .eng_done(eng_done),
        .eng_tanh(eng_tanh), .rsp_valid(rsp_valid), .rsp_id(rsp_id),
        .rsp_tanh(rsp_tanh), .rsp_err(rsp_err), .busy(busy)
    );

    always #5 Clk = ~Clk;

    // Count engine start pulses, sampled away from the active edge.
    always @(negedge Clk) if (eng_start === 1'b1) n_start++;

    task automatic step();
        @(posedge Clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Step until eng_start is seen (bounded); returns the number of steps taken.
    task automatic wait_start(output int n);
        n = 0;
        while (eng_start !== 1'b1 && n < 8) begin
            step();
            n++;
        end
        chk("start_seen", {63'd0, eng_start}, 64'd1);
    endtask

    // One full transaction: expect id to be granted one cycle after the call,
    // return res lat cycles after eng_start, check the response cycle.
    task automatic run_txn(input int id, input int lat, input logic [TANH_W-1:0] res,
                           input logic [NREQ-1:0] raise);
        int n;
        logic early;
        logic [NREQ-1:0] exp_ack;
        exp_ack = 4'b0001 << id;
        wait_start(n);
        chk("grant_lat", 64'(n), 64'd1);
        chk("ack", 64'(ack), 64'(exp_ack));
        chk("eng_angle", 64'(eng_angle), 64'(ang_arr[id]));
        chk("busy_issue", {63'd0, busy}, 64'd1);
        req[id] = 1'b0;
        req = req | raise;
        early = 1'b0;
        repeat (lat) begin
            step();
            if (rsp_valid !== 1'b0) early = 1'b1;
        end
        eng_done = 1'b1;
        eng_tanh = res;
        step();
        eng_done = 1'b0;
        eng_tanh = '0;
        chk("rsp_early", {63'd0, early}, 64'd0);
        chk("rsp_valid", {63'd0, rsp_valid}, 64'd1);
        chk("rsp_id", 64'(rsp_id), 64'(id));
        chk("rsp_tanh", 64'(rsp_tanh), 64'(res));
        chk("rsp_err", {63'd0, rsp_err}, 64'd0);
        step();
        chk("rsp_drop", {63'd0, rsp_valid}, 64'd0);
        chk("busy_idle", {63'd0, busy}, 64'd0);
    endtask

    initial begin
        int n;
        logic seen;
        Reset    = 1'b0;
        req      = '0;
        eng_done = 1'b0;
        eng_tanh = '0;
        ang_arr[0] = ANGLE_ONE;
        ang_arr[1] = 16'hF000;
        ang_arr[2] = 16'h0800;
        ang_arr[3] = 16'h7FFF;

        // Reset state
        step();
        step();
        chk("reset_outs", 64'({ack, eng_start, eng_angle, rsp_valid, rsp_id, rsp_tanh, rsp_err, busy}), 64'd0);
        Reset = 1'b1;
        step();

        // All four requesting with pointer at 0: served 0,1,2,3
        n_start = 0;
        req = 4'b1111;
        run_txn(0, 2, 17'h00100, 4'b0000);
        run_txn(1, 3, 17'h1F000, 4'b0000);
        run_txn(2, 1, 17'h00ABC, 4'b0000);
        run_txn(3, 5, 17'h0FFFF, 4'b0000);
        chk("start_count", 64'(n_start), 64'd4);

        // After id 2, pending 0 and 3: 3 goes first
        req = 4'b0100;
        run_txn(2, 4, 17'h00042, 4'b1001);
        run_txn(3, 2, 17'h00033, 4'b0000);
        run_txn(0, 2, 17'h00011, 4'b0000);

        // Single request, angle 1.0, result after 26 cycles
        ang_arr[1] = 16'h1000;
        req = 4'b0010;
        run_txn(1, 26, 17'h0185F, 4'b0000);

        // eng_done during ISSUE is ignored
        req = 4'b0100;
        wait_start(n);
        req = '0;
        eng_done = 1'b1;
        eng_tanh = 17'h01234;
        step();
        eng_done = 1'b0;
        eng_tanh = '0;
        seen = 1'b0;
        repeat (2) begin
            step();
            if (rsp_valid !== 1'b0) seen = 1'b1;
        end
        chk("issue_done_ignored", {63'd0, seen}, 64'd0);
        eng_done = 1'b1;
        eng_tanh = 17'h1E7A1;
        step();
        eng_done = 1'b0;
        chk("late_rsp_valid", {63'd0, rsp_valid}, 64'd1);
        chk("late_rsp_id", 64'(rsp_id), 64'd2);
        chk("late_rsp_tanh", 64'(rsp_tanh), 64'h1E7A1);
        step();

        // Timeout: no eng_done, response TMO+1 cycles after eng_start
        req = 4'b1000;
        wait_start(n);
        req = '0;
        eng_tanh = 17'h1FFFF;
        seen = 1'b0;
        repeat (TMO) begin
            step();
            if (rsp_valid !== 1'b0) seen = 1'b1;
        end
        chk("tmo_early", {63'd0, seen}, 64'd0);
        step();
        chk("tmo_valid", {63'd0, rsp_valid}, 64'd1);
        chk("tmo_err", {63'd0, rsp_err}, 64'd1);
        chk("tmo_tanh", 64'(rsp_tanh), 64'd0);
        chk("tmo_id", 64'(rsp_id), 64'd3);
        eng_tanh = '0;
        step();

        // Normal request after timeout, then eng_done on the timeout cycle wins
        req = 4'b0001;
        run_txn(0, 5, 17'h000FF, 4'b0000);
        req = 4'b0010;
        run_txn(1, TMO, 17'h00777, 4'b0000);

        // Reset mid-WAIT drops the request; a late eng_done is ignored
        req = 4'b0100;
        wait_start(n);
        req = '0;
        repeat (3) step();
        chk("busy_wait", {63'd0, busy}, 64'd1);
        Reset = 1'b0;
        step();
        chk("midreset_outs", 64'({ack, eng_start, eng_angle, rsp_valid, rsp_id, rsp_tanh, rsp_err, busy}), 64'd0);
        Reset = 1'b1;
        eng_done = 1'b1;
        eng_tanh = 17'h00555;
        step();
        eng_done = 1'b0;
        eng_tanh = '0;
        seen = 1'b0;
        repeat (5) begin
            if (rsp_valid !== 1'b0 || busy !== 1'b0) seen = 1'b1;
            step();
        end
        chk("post_reset_quiet", {63'd0, seen}, 64'd0);
        // Pointer back at 0: with 0 and 3 pending, 0 is picked first
        req = 4'b1001;
        run_txn(0, 2, 17'h00200, 4'b0000);
        run_txn(3, 2, 17'h00300, 4'b0000);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
